bus_dest_regs: RTL and testbench
================================

# bus_dest_regs

Destination side of the shared 8-bit datapath bus. It holds the register set that the bus source multiplexer reads from (PC, DR, AR, TR, AC, R) and loads the selected register from the bus value under a valid/ready write handshake. 16-bit TR and AC are loaded over two byte beats. Selecting code 7 issues a data-memory write cycle. It sits beside the source multiplexer, driven by the control unit, with its register outputs fed back as multiplexer inputs.

## Interface

- PC_RESET, 8'd0, PC value loaded on reset

- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clock
- bus_in  in  8  current bus value from the source multiplexer
- wr_valid  in  1  write request; a transfer occurs on an edge where wr_valid && wr_ready
- wr_sel  in  3  destination: 0 none, 1 PC, 2 DR, 3 AR, 4 TR, 5 AC, 6 R, 7 DM
- pc_inc  in  1  PC increment request
- ac_clr  in  1  AC clear request
- wr_ready  out  1  block can accept a transfer this cycle
- pc, dr, ar, r  out  8  8-bit registers
- tr, ac  out  16  16-bit registers
- wide_pending  out  1  low byte of TR/AC captured, high byte awaited
- dm_we  out  1  one-cycle data-memory write strobe
- dm_addr  out  8  data-memory address, always equal to ar
- dm_wdata  out  8  data-memory write data
- err  out  1  sticky protocol error flag

## Operation

- States: IDLE, WIDE_HI, DM_WR. wr_ready = 1 in IDLE and WIDE_HI, 0 in DM_WR, and 0 while reset_n is low.
- IDLE, accepted sel 1/2/3/6: load bus_in into the target register. Stay in IDLE.
- IDLE, accepted sel 4/5: latch bus_in as lo_byte and the target. Go to WIDE_HI.
- WIDE_HI, accepted write with the same sel: target <= {bus_in, lo_byte}, both bytes updated at once. Go to IDLE.
- WIDE_HI, accepted write with a different sel: discard lo_byte, set err, then process the new write exactly as from IDLE. This includes entering WIDE_HI again if the new sel is 4 or 5.
- TR and AC never show a partially written value.
- Accepted sel 7 (from IDLE, or from WIDE_HI with err set and the wide load aborted): dm_wdata <= bus_in. Go to DM_WR. In DM_WR, dm_we = 1 for exactly one cycle, then return to IDLE. Writes presented during DM_WR are not accepted.
- sel 0 with wr_valid: no register change, no state change. In WIDE_HI the pending load is kept.
- pc_inc: pc <= pc + 1, modulo 256 (255 wraps to 0). An accepted PC write in the same cycle wins over pc_inc.
- ac_clr: ac <= 0. The completing high-byte AC write in the same cycle wins over ac_clr. ac_clr during WIDE_HI does not abort the pending load.
- err: set only by an aborted wide load; cleared only by reset.
- wide_pending = 1 exactly while in WIDE_HI.

## Timing

- Reset (reset_n low at an edge): pc = PC_RESET. dr, ar, r, tr, ac, lo_byte = 0. dm_wdata = 0, dm_we = 0, err = 0, state IDLE, wide_pending = 0.
- Reset mid-operation: in WIDE_HI the lo_byte is discarded. In DM_WR, dm_we is 0 after the reset edge.
- 8-bit write latency: the register shows the new value on the cycle after the accepting edge.
- Wide write: two accepted beats, not necessarily consecutive. The full 16-bit value is visible the cycle after the second beat.
- DM write: dm_we is high the cycle after the accepting edge, with dm_addr/dm_wdata stable that cycle. wr_ready is low that same cycle.
- Back-to-back narrow writes are accepted every cycle.

## Test plan

- Reset, then write sel 1 with 8'h3C, then assert pc_inc for 3 cycles -> pc = 8'h3C, 8'h3D, 8'h3E, 8'h3F. Then load 8'hFF and pc_inc -> pc = 8'h00.
- sel 5 beats 8'h34 then 8'h12 -> ac = 16'h1234 after the second beat, unchanged after the first. wide_pending is high between the beats.
- sel 4 beat 8'hAA, then sel 2 with 8'h55 -> err = 1, tr unchanged, dr = 8'h55, wide_pending = 0.
- sel 3 with 8'h80, then sel 7 with 8'h9D -> next cycle dm_we = 1, dm_addr = 8'h80, dm_wdata = 8'h9D, wr_ready = 0. A sel 6 write held during that cycle is accepted the following cycle.
- Same cycle: sel 1 write 8'h10 with pc_inc -> pc = 8'h10. Same cycle: ac_clr with a completing AC high beat -> ac = written value.
- reset_n low while in WIDE_HI and in DM_WR -> all outputs at reset values next cycle, and err remains 0 afterwards.

Source files
------------

// File: rtl/bus_dest_regs.sv
`default_nettype none
// ==========================================================================
// bus_dest_regs : destination register set of the 8-bit datapath bus,
//                 loaded under a valid/ready handshake (TR/AC in two beats)
// Rev 1.0
// ==========================================================================
module bus_dest_regs #(
  parameter logic [7:0] PC_RESET = 8'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  bus_in,
  input  logic        wr_valid,
  input  logic [2:0]  wr_sel,
  input  logic        pc_inc,
  input  logic        ac_clr,
  output logic        wr_ready,
  output logic [7:0]  pc,
  output logic [7:0]  dr,
  output logic [7:0]  ar,
  output logic [7:0]  r,
  output logic [15:0] tr,
  output logic [15:0] ac,
  output logic        wide_pending,
  output logic        dm_we,
  output logic [7:0]  dm_addr,
  output logic [7:0]  dm_wdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WIDE_HI = 2'd1,
    DM_WR   = 2'd2
  } state_t;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_PC   = 3'd1;
  localparam logic [2:0] SEL_DR   = 3'd2;
  localparam logic [2:0] SEL_AR   = 3'd3;
  localparam logic [2:0] SEL_TR   = 3'd4;
  localparam logic [2:0] SEL_AC   = 3'd5;
  localparam logic [2:0] SEL_R    = 3'd6;
  localparam logic [2:0] SEL_DM   = 3'd7;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  dr_q, dr_d;
  logic [7:0]  ar_q, ar_d;
  logic [7:0]  r_q, r_d;
  logic [15:0] tr_q, tr_d;
  logic [15:0] ac_q, ac_d;
  logic [7:0]  lo_byte_q, lo_byte_d;
  logic [2:0]  wide_sel_q, wide_sel_d;
  logic [7:0]  dm_wdata_q, dm_wdata_d;
  logic        err_q, err_d;
  logic        accept;

  assign wr_ready = reset_n && (state_q != DM_WR);
  assign accept   = wr_valid && wr_ready;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dr_d       = dr_q;
    ar_d       = ar_q;
    r_d        = r_q;
    tr_d       = tr_q;
    ac_d       = ac_q;
    lo_byte_d  = lo_byte_q;
    wide_sel_d = wide_sel_q;
    dm_wdata_d = dm_wdata_q;
    err_d      = err_q;

    if (pc_inc) pc_d = pc_q + 8'd1;
    if (ac_clr) ac_d = 16'd0;
    if (state_q == DM_WR) state_d = IDLE;

    if (accept && (wr_sel != SEL_NONE)) begin
      if ((state_q == WIDE_HI) && (wr_sel == wide_sel_q)) begin
        // Both bytes land together so TR/AC never show a half-written value
        if (wide_sel_q == SEL_TR) tr_d = {bus_in, lo_byte_q};
        else                      ac_d = {bus_in, lo_byte_q};
        state_d = IDLE;
      end else begin
        if (state_q == WIDE_HI) err_d = 1'b1;
        state_d = IDLE;
        case (wr_sel)
          SEL_PC: pc_d = bus_in;
          SEL_DR: dr_d = bus_in;
          SEL_AR: ar_d = bus_in;
          SEL_R:  r_d  = bus_in;
          SEL_TR, SEL_AC: begin
            lo_byte_d  = bus_in;
            wide_sel_d = wr_sel;
            state_d    = WIDE_HI;
          end
          SEL_DM: begin
            dm_wdata_d = bus_in;
            state_d    = DM_WR;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_RESET;
      dr_q       <= 8'd0;
      ar_q       <= 8'd0;
      r_q        <= 8'd0;
      tr_q       <= 16'd0;
      ac_q       <= 16'd0;
      lo_byte_q  <= 8'd0;
      wide_sel_q <= SEL_NONE;
      dm_wdata_q <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dr_q       <= dr_d;
      ar_q       <= ar_d;
      r_q        <= r_d;
      tr_q       <= tr_d;
      ac_q       <= ac_d;
      lo_byte_q  <= lo_byte_d;
      wide_sel_q <= wide_sel_d;
      dm_wdata_q <= dm_wdata_d;
      err_q      <= err_d;
    end
  end

  assign pc           = pc_q;
  assign dr           = dr_q;
  assign ar           = ar_q;
  assign r            = r_q;
  assign tr           = tr_q;
  assign ac           = ac_q;
  assign wide_pending = (state_q == WIDE_HI);
  assign dm_we        = (state_q == DM_WR);
  assign dm_addr      = ar_q;
  assign dm_wdata     = dm_wdata_q;
  assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_dest_regs.sv
`default_nettype none
// ==========================================================================
// tb_bus_dest_regs : directed + random stimulus against a transaction model
// Rev 1.0
// ==========================================================================
module tb_bus_dest_regs;

  logic        clock;
  logic        reset_n;
  logic [7:0]  bus_in;
  logic        wr_valid;
  logic [2:0]  wr_sel;
  logic        pc_inc;
  logic        ac_clr;
  logic        wr_ready;
  logic [7:0]  pc, dr, ar, r;
  logic [15:0] tr, ac;
  logic        wide_pending;
  logic        dm_we;
  logic [7:0]  dm_addr, dm_wdata;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Reference model: narrow registers indexed by destination code
  logic [7:0]  m_reg [0:7];
  logic [15:0] m_tr, m_ac;
  int          m_mode;     // 0 idle, 1 awaiting high byte, 2 memory write cycle
  int          m_tgt;
  logic [7:0]  m_lo, m_wdata;
  logic        m_err;

  bus_dest_regs #(.PC_RESET(8'd0)) dut (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in), .wr_valid(wr_valid),
    .wr_sel(wr_sel), .pc_inc(pc_inc), .ac_clr(ac_clr), .wr_ready(wr_ready),
    .pc(pc), .dr(dr), .ar(ar), .r(r), .tr(tr), .ac(ac),
    .wide_pending(wide_pending), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .err(err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'd0;
    m_tr = 16'd0; m_ac = 16'd0; m_mode = 0; m_tgt = 0;
    m_lo = 8'd0; m_wdata = 8'd0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [7:0]  nxt_pc;
    logic [15:0] nxt_ac;
    int          nxt_mode;
    int          s;
    if (!reset_n) begin
      model_reset();
      return;
    end
    s        = int'(wr_sel);
    nxt_pc   = pc_inc ? m_reg[1] + 8'd1 : m_reg[1];
    nxt_ac   = ac_clr ? 16'd0 : m_ac;
    nxt_mode = 0;
    if (m_mode == 1) nxt_mode = 1;
    if (wr_valid && m_mode != 2 && s != 0) begin
      if (m_mode == 1 && s == m_tgt) begin
        if (s == 4) m_tr = {bus_in, m_lo};
        else        nxt_ac = {bus_in, m_lo};
        nxt_mode = 0;
      end else begin
        if (m_mode == 1) m_err = 1'b1;
        nxt_mode = 0;
        if (s == 1) nxt_pc = bus_in;
        else if (s == 2 || s == 3 || s == 6) m_reg[s] = bus_in;
        else if (s == 4 || s == 5) begin
          m_lo = bus_in; m_tgt = s; nxt_mode = 1;
        end else begin
          m_wdata = bus_in; nxt_mode = 2;
        end
      end
    end
    m_reg[1] = nxt_pc;
    m_ac     = nxt_ac;
    m_mode   = nxt_mode;
  endtask

  task automatic compare_all();
    check_eq("pc", {8'd0, pc}, {8'd0, m_reg[1]});
    check_eq("dr", {8'd0, dr}, {8'd0, m_reg[2]});
    check_eq("ar", {8'd0, ar}, {8'd0, m_reg[3]});
    check_eq("r", {8'd0, r}, {8'd0, m_reg[6]});
    check_eq("tr", tr, m_tr);
    check_eq("ac", ac, m_ac);
    check_eq("wide_pending", {15'd0, wide_pending}, {15'd0, m_mode == 1});
    check_eq("dm_we", {15'd0, dm_we}, {15'd0, m_mode == 2});
    check_eq("dm_addr", {8'd0, dm_addr}, {8'd0, m_reg[3]});
    check_eq("dm_wdata", {8'd0, dm_wdata}, {8'd0, m_wdata});
    check_eq("err", {15'd0, err}, {15'd0, m_err});
  endtask

  // One clock cycle: drive, check ready mid-cycle, clock, compare after edge
  task automatic cyc(input logic rn, input logic v, input logic [2:0] sel,
                     input logic [7:0] b, input logic inc, input logic clr);
    reset_n = rn; wr_valid = v; wr_sel = sel; bus_in = b; pc_inc = inc; ac_clr = clr;
    #4;
    check_eq("wr_ready", {15'd0, wr_ready}, {15'd0, rn && m_mode != 2});
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int s;
    model_reset();
    m_reg[1] = 8'hEE; // force a genuine reset check
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 8'h99, 1, 0);
    check_eq("reset_pc", {8'd0, pc}, 16'h0000);

    cyc(1, 1, 1, 8'h3C, 0, 0);
    check_eq("pc_load", {8'd0, pc}, 16'h003C);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check_eq("pc_inc3", {8'd0, pc}, 16'h003F);
    cyc(1, 1, 1, 8'hFF, 0, 0);
    cyc(1, 0, 0, 0, 1, 0);
    check_eq("pc_wrap", {8'd0, pc}, 16'h0000);

    cyc(1, 1, 5, 8'h34, 0, 0);
    check_eq("ac_lo_hidden", ac, 16'h0000);
    check_eq("wide_pend_hi", {15'd0, wide_pending}, 16'h0001);
    cyc(1, 1, 0, 8'h77, 0, 0);
    cyc(1, 1, 5, 8'h12, 0, 0);
    check_eq("ac_wide", ac, 16'h1234);

    cyc(1, 1, 4, 8'hAA, 0, 0);
    cyc(1, 1, 2, 8'h55, 0, 0);
    check_eq("abort_err", {15'd0, err}, 16'h0001);
    check_eq("abort_tr", tr, 16'h0000);
    check_eq("abort_dr", {8'd0, dr}, 16'h0055);
    check_eq("abort_wp", {15'd0, wide_pending}, 16'h0000);

    cyc(1, 1, 3, 8'h80, 0, 0);
    cyc(1, 1, 7, 8'h9D, 0, 0);
    check_eq("dm_we_hi", {15'd0, dm_we}, 16'h0001);
    check_eq("dm_addr_80", {8'd0, dm_addr}, 16'h0080);
    check_eq("dm_wdata_9d", {8'd0, dm_wdata}, 16'h009D);
    check_eq("dm_ready_lo", {15'd0, wr_ready}, 16'h0000);
    cyc(1, 1, 6, 8'h66, 0, 0);
    check_eq("r_blocked", {8'd0, r}, 16'h0000);
    check_eq("dm_we_once", {15'd0, dm_we}, 16'h0000);
    cyc(1, 1, 6, 8'h66, 0, 0);
    check_eq("r_after_dm", {8'd0, r}, 16'h0066);

    cyc(1, 1, 1, 8'h10, 1, 0);
    check_eq("pc_write_wins", {8'd0, pc}, 16'h0010);
    cyc(1, 1, 5, 8'h01, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    check_eq("clr_keeps_pend", {15'd0, wide_pending}, 16'h0001);
    cyc(1, 1, 5, 8'h02, 0, 1);
    check_eq("ac_hi_wins", ac, 16'h0201);

    cyc(0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4, 8'hC3, 0, 0);
    cyc(0, 1, 4, 8'h11, 0, 0);
    check_eq("rst_wide_wp", {15'd0, wide_pending}, 16'h0000);
    cyc(1, 1, 4, 8'h22, 0, 0);
    cyc(1, 1, 4, 8'h33, 0, 0);
    check_eq("rst_wide_lo", tr, 16'h3322);
    cyc(1, 1, 7, 8'h5A, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check_eq("rst_dm_we", {15'd0, dm_we}, 16'h0000);
    cyc(1, 0, 0, 0, 0, 0);
    check_eq("rst_err_zero", {15'd0, err}, 16'h0000);

    for (int i = 0; i < 600; i++) begin
      s = int'($urandom_range(0, 7));
      if (m_mode == 1 && $urandom_range(0, 1) == 1) s = m_tgt;
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 9) < 7, 3'(s),
          8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
